// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences weight load, bank swap, data streaming and drain for one systolic array tile
module systolic_ctrl #(
    parameter int N            = 4,
    parameter int DRAIN_CYCLES = 2 * N,
    parameter int CW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] num_vectors,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic          d_valid,
    output logic          d_ready,
    output logic          load_weight,
    output logic          swap_weights,
    output logic          run,
    output logic          data_zero,
    output logic          busy,
    output logic          done
);
    localparam int LW = $clog2(N + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SWAP, STREAM, DRAIN, DONE} state_t;

    state_t        state;
    logic [LW-1:0] load_cnt;
    logic [DW-1:0] drain_cnt;
    logic [CW-1:0] vec_cnt;
    logic [CW-1:0] vec_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            load_cnt  <= '0;
            drain_cnt <= '0;
            vec_cnt   <= '0;
            vec_tgt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    vec_tgt   <= num_vectors;
                    load_cnt  <= '0;
                    drain_cnt <= '0;
                    vec_cnt   <= '0;
                    state     <= LOAD;
                end
                LOAD: if (w_valid) begin
                    load_cnt <= load_cnt + LW'(1);
                    state    <= (load_cnt == LW'(N - 1)) ? SWAP : LOAD;
                end
                SWAP: state <= (vec_tgt != '0) ? STREAM : DONE;
                // compare against vec_tgt-1 so a full-scale count never needs vec_cnt to wrap
                STREAM: if (d_valid) begin
                    vec_cnt <= vec_cnt + CW'(1);
                    state   <= (vec_cnt == vec_tgt - CW'(1)) ? DRAIN : STREAM;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    state     <= (drain_cnt == DW'(DRAIN_CYCLES - 1)) ? DONE : DRAIN;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // outputs are forced low while rst is high so a reset cycle never leaks a stale control
    assign w_ready      = !rst && state == LOAD && w_valid;
    assign load_weight  = w_ready;
    assign d_ready      = !rst && state == STREAM && d_valid;
    assign swap_weights = !rst && state == SWAP;
    assign data_zero    = !rst && state == DRAIN;
    assign run          = d_ready || data_zero;
    assign busy         = !rst && state != IDLE;
    assign done         = !rst && state == DONE;
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: randomized tiles checked cycle by cycle against a phase-timeline model
module tb_systolic_ctrl;
    localparam int N    = 4;
    localparam int D    = 2 * N;
    localparam int MAXC = 65600;

    logic        clk = 1'b0;
    logic        rst, start, w_valid, d_valid;
    logic [15:0] num_vectors;
    logic        w_ready, d_ready, load_weight, swap_weights, run, data_zero, busy, done;

    int compared   = 0;
    int mismatched = 0;
    int last_done;
    bit wv [MAXC];
    bit dv [MAXC];

    systolic_ctrl #(.N(N), .DRAIN_CYCLES(D), .CW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
        .w_valid(w_valid), .w_ready(w_ready), .d_valid(d_valid), .d_ready(d_ready),
        .load_weight(load_weight), .swap_weights(swap_weights), .run(run),
        .data_zero(data_zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {w_ready, d_ready, load_weight, swap_weights, run, data_zero, busy, done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        w_valid = 1'($urandom); d_valid = 1'($urandom); num_vectors = 16'($urandom);
        #1;
        chk("idle", 32'(outs()), 32'h0);
    endtask

    // wmode/dmode: 0 all ones, 1 pattern (w toggling / d 5-cycle gap), 2 random
    task automatic run_tile(input int nv, input int wmode, input int dmode, input int rst_at, input bit hold);
        int c, l_end, s_t, m_end, t_done, last_t, lw_n, rd_n, rz_n, dn_n;
        logic [7:0] exp;
        logic e_wr, e_dr, e_dz;
        for (int t = 0; t < MAXC; t++)
            wv[t] = wmode == 0 ? 1'b1 : wmode == 1 ? t[0] : ($urandom_range(0, 99) < 70);
        c = 0; l_end = 0;
        for (int t = 1; c < N; t++) begin
            if (wv[t]) c++;
            l_end = t;
        end
        s_t = l_end + 1;
        for (int t = 0; t < MAXC; t++)
            dv[t] = dmode == 0 ? 1'b1 : dmode == 1 ? !(t >= s_t + 2 && t <= s_t + 6) : ($urandom_range(0, 99) < 60);
        c = 0; m_end = s_t;
        if (nv > 0)
            for (int t = s_t + 1; c < nv; t++) begin
                if (dv[t]) c++;
                m_end = t;
            end
        t_done = nv > 0 ? m_end + D + 1 : s_t + 1;
        last_t = rst_at >= 0 ? rst_at + 1 : t_done;
        lw_n = 0; rd_n = 0; rz_n = 0; dn_n = 0; last_done = -1;
        for (int t = 0; t <= last_t; t++) begin
            @(negedge clk);
            rst = (t == rst_at);
            start = (hold || t == 0) && !(rst_at >= 0 && t == rst_at + 1);
            num_vectors = t == 0 ? 16'(nv) : 16'($urandom);
            w_valid = wv[t]; d_valid = dv[t];
            #1;
            e_wr = (t >= 1 && t <= l_end) ? wv[t] : 1'b0;
            e_dr = (nv > 0 && t > s_t && t <= m_end) ? dv[t] : 1'b0;
            e_dz = nv > 0 && t > m_end && t <= m_end + D;
            exp = {e_wr, e_dr, e_wr, 1'(t == s_t), e_dr | e_dz, e_dz, 1'(t >= 1), 1'(t == t_done)};
            if (rst_at >= 0 && t >= rst_at) exp = 8'h0;
            chk("cycle", 32'(outs()), 32'(exp));
            chk("excl", 32'($onehot0({load_weight, swap_weights, run})), 32'd1);
            lw_n += int'(load_weight);
            rd_n += int'(run && !data_zero);
            rz_n += int'(run && data_zero);
            dn_n += int'(done);
            if (done) last_done = t;
        end
        if (rst_at < 0) begin
            chk("load_pulses", 32'(lw_n), 32'(N));
            chk("data_runs", 32'(rd_n), 32'(nv));
            chk("drain_runs", 32'(rz_n), nv > 0 ? 32'(D) : 32'd0);
            chk("done_pulses", 32'(dn_n), 32'd1);
        end else
            chk("done_after_rst", 32'(dn_n), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; w_valid = 1'b0; d_valid = 1'b0; num_vectors = '0;
        repeat (2) begin
            @(negedge clk);
            start = 1'b1; w_valid = 1'b1; d_valid = 1'b1;
            #1;
            chk("in_reset", 32'(outs()), 32'h0);
        end
        idle_cycle();
        run_tile(3, 0, 0, -1, 1'b0);
        chk("latency_3vec", 32'(last_done), 32'd17);
        idle_cycle();
        run_tile(0, 0, 0, -1, 1'b0);
        chk("latency_0vec", 32'(last_done), 32'd6);
        idle_cycle();
        run_tile(3, 1, 0, -1, 1'b0);
        idle_cycle();
        run_tile(5, 0, 1, -1, 1'b0);
        idle_cycle();
        run_tile(3, 0, 0, 11, 1'b0);
        run_tile(3, 0, 0, -1, 1'b0);
        chk("latency_after_rst", 32'(last_done), 32'd17);
        idle_cycle();
        run_tile(4, 2, 2, 2, 1'b0);
        run_tile(2, 0, 0, -1, 1'b1);
        run_tile(1, 2, 2, -1, 1'b1);
        run_tile(2, 0, 0, -1, 1'b0);
        idle_cycle();
        for (int i = 0; i < 8; i++) begin
            bit h;
            h = 1'($urandom);
            run_tile(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1, h);
            if (!h) idle_cycle();
        end
        run_tile(65535, 0, 0, -1, 1'b0);
        idle_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter N, default 4: array dimension; weight chain length per column and number of weight load cycles per tile.
REQ-002 Parameter DRAIN_CYCLES, default 2*N: run cycles issued after the last data vector to flush the pipeline.
REQ-003 Parameter CW, default 16: width of vector count.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to process one tile; sampled only in IDLE.
REQ-007 num_vectors  input  CW  data vectors in tile; latched when start is accepted.
REQ-008 w_valid  input  1  weight source has a word available.
REQ-009 w_ready  output  1  weight word consumed this cycle.
REQ-010 d_valid  input  1  data source has a vector available.
REQ-011 d_ready  output  1  data vector consumed this cycle.
REQ-012 load_weight  output  1  array weight shift enable.
REQ-013 swap_weights  output  1  array active/shadow weight bank toggle.
REQ-014 run  output  1  array data/accumulator pipeline enable.
REQ-015 data_zero  output  1  array data inputs forced to 0 (drain bubbles).
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at tile completion.

Function
REQ-018 States: IDLE, LOAD, SWAP, STREAM, DRAIN, DONE; encoded in one state register.
REQ-019 IDLE: start=1 -> latch num_vectors into vec_tgt, clear counters, go LOAD next cycle; start in any other state ignored (not queued).
REQ-020 LOAD: load_weight = w_ready = w_valid; load_cnt increments per accepted word; w_valid=0 stalls with load_weight=0 and no count change.
REQ-021 LOAD -> SWAP on the cycle the N-th word is accepted (load_cnt==N-1 and w_valid); exactly N load_weight pulses per tile.
REQ-022 SWAP: swap_weights=1 for exactly one cycle; all other array controls 0; next state STREAM if vec_tgt!=0, else DONE.
REQ-023 STREAM: run = d_ready = d_valid; data_zero=0; vec_cnt increments per accepted vector; d_valid=0 freezes the whole array (run=0).
REQ-024 STREAM -> DRAIN on the cycle vector vec_tgt is accepted (vec_cnt==vec_tgt-1 and d_valid).
REQ-025 DRAIN: run=1, data_zero=1, d_ready=0 every cycle for exactly DRAIN_CYCLES cycles (drain_cnt 0..DRAIN_CYCLES-1), then DONE.
REQ-026 DONE: done=1 for one cycle, busy=1, all array controls 0; next state IDLE unconditionally; start in DONE ignored.
REQ-027 w_ready only asserted in LOAD; d_ready only in STREAM; load_weight, swap_weights, run never asserted in IDLE or DONE.
REQ-028 load_weight, swap_weights, run mutually exclusive in every cycle.
REQ-029 Outputs combinational from state register and w_valid/d_valid; counters and state registered; no combinational path start->any output.
REQ-030 Counters CW bits wide (load_cnt, drain_cnt sized to their parameter); vec_cnt never wraps: num_vectors = 2^CW-1 is legal and processed in full.
REQ-031 Back-to-back tiles: minimum IDLE dwell one cycle between DONE and next LOAD.

Reset
REQ-032 rst=1 at a clock edge -> state IDLE, load_cnt/vec_cnt/drain_cnt/vec_tgt = 0, regardless of current state (including mid-LOAD/STREAM/DRAIN).
REQ-033 While in reset and the cycle after: w_ready, d_ready, load_weight, swap_weights, run, data_zero, busy, done all 0.
REQ-034 Partially loaded tile at reset is abandoned; no swap_weights or done issued for it.

Verification
REQ-035 N=4, start, num_vectors=3, w_valid/d_valid held 1 -> 4 load_weight cycles, 1 swap, 3 run with data_zero=0, 8 run with data_zero=1, done pulse; start-to-done 17 cycles.
REQ-036 w_valid toggling 1,0,1,0... in LOAD -> exactly 4 load_weight pulses, each coincident with w_valid=1; SWAP follows the 4th.
REQ-037 d_valid low 5 cycles mid-STREAM -> run=0, d_ready=0 for those 5 cycles, vec_cnt held, total data run pulses still equals num_vectors.
REQ-038 num_vectors=0 -> LOAD(4), SWAP, DONE; zero run pulses, done 6 cycles after start.
REQ-039 rst asserted in 3rd DRAIN cycle -> next cycle IDLE, all outputs 0, no done; subsequent start runs full tile correctly.
REQ-040 start held high continuously -> start ignored while busy; new tile begins one cycle after DONE's IDLE dwell; checker verifies REQ-028 every cycle.
